lcd_char_ctrl: RTL and testbench

Parametrised HD44780-class character-LCD controller behind an Avalon-MM slave, the successor to the current combinational LCD pass-through. It generates properly timed RS/RW/E bus cycles from a single clock, supports 8-bit or 4-bit LCD data buses, and stalls the master with `waitrequest` until each LCD bus cycle completes. It sits between the system interconnect and the board LCD header.

---
 rtl/lcd_char_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_char_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_ctrl.sv
`timescale 1ns/1ps
// lcd_char_ctrl: HD44780-class character-LCD controller behind an Avalon-MM slave.
// Generates timed RS/RW/E bus cycles for an 8-bit or 4-bit (DB7..DB4) LCD bus and
// holds waitrequest until the LCD cycle is complete.
// Optional feature macro: LCD_BUSY_POLL_EN -- after each write, automatically run
// status reads until the busy flag (bit7) reads 0 before releasing the master.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no LCD cycle; bus released; waiting for read or write strobe
// S_SETUP | RS/RW (and write data) presented, E low, T_AS cycles
// S_EHIGH | E high for T_EH cycles; read data sampled on the last one
// S_HOLD  | E low, RS/RW/data held for T_AH cycles; nibble/poll decision
module lcd_char_ctrl #(
  parameter int BUS_W = 8,
  parameter int T_AS  = 2,
  parameter int T_EH  = 12,
  parameter int T_AH  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  output logic             waitrequest,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW,
  inout  wire  [BUS_W-1:0] LCD_data
);

  localparam int T_MAX1 = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int T_MAX  = (T_MAX1 > T_AH) ? T_MAX1 : T_AH;
  localparam int CNT_W  = $clog2(T_MAX + 1);

  // Down-counter load values: the phase ends when the counter reaches zero.
  localparam logic [CNT_W-1:0] AS_LD = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] EH_LD = CNT_W'(T_EH - 1);
  localparam logic [CNT_W-1:0] AH_LD = CNT_W'(T_AH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_EHIGH = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
`ifdef LCD_BUSY_POLL_EN
  logic             poll_q, poll_d;
  logic             bf_q, bf_d;
  logic             bf_in;
`endif

  logic [BUS_W-1:0] bus_out;
  logic [7:0]       rd_merge;
  logic             last_nib;
  logic             seq_end;
  logic             poll_more;
  logic             done;

  // Map the byte onto the physical bus: whole byte, or high nibble then low nibble.
  generate
    if (BUS_W == 4) begin : g_bus4
      assign bus_out  = nib_q ? wdata_q[3:0] : wdata_q[7:4];
      assign rd_merge = nib_q ? {rdata_q[7:4], LCD_data} : {LCD_data, rdata_q[3:0]};
    end else begin : g_bus8
      assign bus_out  = wdata_q;
      assign rd_merge = LCD_data;
    end
  endgenerate

  assign last_nib = (BUS_W == 4) ? nib_q : 1'b1;
  assign seq_end  = (state_q == S_HOLD) && (cnt_q == '0) && last_nib;

`ifdef LCD_BUSY_POLL_EN
  // BF is the bus MSB of the first (or only) phase of a status read.
  assign bf_in     = LCD_data[BUS_W-1];
  assign poll_more = seq_end && (poll_q ? bf_q : ~rw_q);
`else
  assign poll_more = 1'b0;
`endif

  assign done        = seq_end && !poll_more;
  assign waitrequest = (read | write) & ~done;

  assign LCD_E    = (state_q == S_EHIGH);
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign readdata = rdata_q;
  assign LCD_data = (!rw_q && state_q != S_IDLE) ? bus_out : {BUS_W{1'bz}};

  // Next-state logic: phase sequencing, nibble stepping, capture of read data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LCD_BUSY_POLL_EN
    poll_d  = poll_q;
    bf_d    = bf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (read | write) begin
          state_d = S_SETUP;
          cnt_d   = AS_LD;
          nib_d   = 1'b0;
          rs_d    = address[1];
          rw_d    = address[0];
          wdata_d = writedata;
`ifdef LCD_BUSY_POLL_EN
          poll_d  = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EHIGH;
          cnt_d   = EH_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EHIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = AH_LD;
`ifdef LCD_BUSY_POLL_EN
          if (poll_q) begin
            if (!nib_q) bf_d = bf_in;
          end else if (rw_q) begin
            rdata_d = rd_merge;
          end
`else
          if (rw_q) rdata_d = rd_merge;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!last_nib) begin
          state_d = S_SETUP;
          cnt_d   = AS_LD;
          nib_d   = 1'b1;
`ifdef LCD_BUSY_POLL_EN
        end else if (poll_more) begin
          // Chain a status read (RS=0, RW=1) with identical timing.
          state_d = S_SETUP;
          cnt_d   = AS_LD;
          nib_d   = 1'b0;
          poll_d  = 1'b1;
          rs_d    = 1'b0;
          rw_d    = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
          nib_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset releases the bus and leaves RW at read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nib_q   <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef LCD_BUSY_POLL_EN
      poll_q  <= 1'b0;
      bf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LCD_BUSY_POLL_EN
      poll_q  <= poll_d;
      bf_q    <= bf_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
`timescale 1ns/1ps
// Bench for lcd_char_ctrl: one 8-bit and one 4-bit instance, directed steps,
// scoreboard of expected latency/readdata checked when waitrequest drops.
module tb_lcd_char_ctrl;
  localparam int TAS = 2;
  localparam int TEH = 12;
  localparam int TAH = 2;
  localparam int PH  = TAS + TEH + TAH;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       read8, write8, read4, write4;
  logic [7:0] rd8, rd4;
  logic       wait8, wait4, e8, rs8, rw8, e4, rs4, rw4;
  wire  [7:0] d8;
  wire  [3:0] d4;
  logic       m8_drv, m4_drv;
  logic [7:0] m8_val;
  logic [3:0] m4_val;

  assign d8 = m8_drv ? m8_val : 8'bz;
  assign d4 = m4_drv ? m4_val : 4'bz;

  lcd_char_ctrl #(.BUS_W(8), .T_AS(TAS), .T_EH(TEH), .T_AH(TAH)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read8), .write(write8),
    .writedata(writedata), .readdata(rd8), .waitrequest(wait8),
    .LCD_E(e8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_data(d8)
  );

  lcd_char_ctrl #(.BUS_W(4), .T_AS(TAS), .T_EH(TEH), .T_AH(TAH)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read4), .write(write4),
    .writedata(writedata), .readdata(rd4), .waitrequest(wait4),
    .LCD_E(e4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_data(d4)
  );

  typedef struct {
    int         lat;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] last_rd8 = 8'h00;
  logic [7:0] last_rd4 = 8'h00;

`ifdef LCD_BUSY_POLL_EN
  int falls8 = 0;
  always @(negedge e8) falls8++;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Avalon transaction with per-cycle LCD pin checks and scoreboard at completion.
  task automatic txn(input bit four, input logic [1:0] addr, input bit rd, input bit wr,
                     input logic [7:0] wd, input logic [7:0] mval, input string tag);
    int         total  = (four ? 2 : 1) * PH;
    int         lat    = total;
    bit         wr_dir = !addr[0];
    bit         done   = 1'b0;
    exp_t       e;
    logic [7:0] bus, exp_bus, mv;
    logic       e_o, rs_o, rw_o, w_o;
    int         j, ph;
`ifdef LCD_BUSY_POLL_EN
    if (wr_dir) lat = 2 * total;
`endif
    e.lat   = lat;
    e.rdata = wr_dir ? (four ? last_rd4 : last_rd8) : mval;
    sb.push_back(e);
    if (!wr_dir) begin
      if (four) last_rd4 = mval;
      else      last_rd8 = mval;
    end
    @(posedge clk); #1;
    address   = addr;
    writedata = wd;
    if (four) begin read4 = rd; write4 = wr; end
    else      begin read8 = rd; write8 = wr; end
    for (int k = 0; k < 4 * total + 8 && !done; k++) begin
      @(negedge clk);
      mv = four ? ((k <= PH) ? {4'h0, mval[7:4]} : {4'h0, mval[3:0]}) : mval;
      if (!wr_dir) mv = mval;
      if (four) begin
        m4_drv = !wr_dir || (k > total);
        m4_val = (!wr_dir) ? ((k <= PH) ? mval[7:4] : mval[3:0]) : 4'h0;
      end else begin
        m8_drv = !wr_dir || (k > total);
        m8_val = (!wr_dir) ? mval : 8'h00;
      end
      #1;
      e_o  = four ? e4 : e8;
      rs_o = four ? rs4 : rs8;
      rw_o = four ? rw4 : rw8;
      w_o  = four ? wait4 : wait8;
      bus  = four ? {4'h0, d4} : d8;
      if (k == 0) chk({tag, " E idle"}, 32'(e_o), 32'(0));
      if (k >= 1 && k <= total) begin
        j  = (k - 1) % PH;
        ph = (k - 1) / PH;
        chk({tag, " E"}, 32'(e_o), 32'(j >= TAS && j < TAS + TEH));
        chk({tag, " RS"}, 32'(rs_o), 32'(addr[1]));
        chk({tag, " RW"}, 32'(rw_o), 32'(addr[0]));
        if (!wr_dir)
          exp_bus = four ? ((ph == 0) ? {4'h0, mval[7:4]} : {4'h0, mval[3:0]}) : mval;
        else
          exp_bus = four ? ((ph == 0) ? {4'h0, wd[7:4]} : {4'h0, wd[3:0]}) : wd;
        chk({tag, " bus"}, 32'(bus), 32'(exp_bus));
      end
      if (!w_o) begin
        done = 1'b1;
        e    = sb.pop_front();
        chk({tag, " latency"}, 32'(k), 32'(e.lat));
        chk({tag, " readdata"}, 32'(four ? rd4 : rd8), 32'(e.rdata));
      end
    end
    chk({tag, " completed"}, 32'(done), 32'(1));
    @(posedge clk); #1;
    read8 = 1'b0; write8 = 1'b0; read4 = 1'b0; write4 = 1'b0;
    m8_drv = 1'b0; m4_drv = 1'b0;
  endtask

  initial begin
    bit done;
    exp_t e;
    int f0;
    reset_n = 1'b1;
    address = 2'b00; writedata = 8'h00;
    read8 = 1'b0; write8 = 1'b0; read4 = 1'b0; write4 = 1'b0;
    m8_drv = 1'b0; m4_drv = 1'b0; m8_val = 8'h00; m4_val = 4'h0;
    #1 reset_n = 1'b0;
    #3;
    chk("rst E", 32'(e8), 32'(0));
    chk("rst RS", 32'(rs8), 32'(0));
    chk("rst RW", 32'(rw8), 32'(1));
    chk("rst readdata", 32'(rd8), 32'(0));
    chk("rst waitrequest", 32'(wait8), 32'(0));
    chk("rst RW4", 32'(rw4), 32'(1));
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    txn(1'b0, 2'd0, 1'b0, 1'b1, 8'h38, 8'h00, "w8 38");
    txn(1'b0, 2'd3, 1'b1, 1'b0, 8'hFF, 8'h5A, "r8 5A");
    txn(1'b0, 2'd1, 1'b0, 1'b1, 8'hFF, 8'h3C, "wstrobe-read 3C");
    txn(1'b0, 2'd2, 1'b1, 1'b1, 8'h41, 8'h00, "both-strobes w 41");

    // Master drops write in cycle 5; the LCD cycle still runs to completion.
    @(posedge clk); #1;
    address = 2'd0; writedata = 8'h55; write8 = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k == 5) write8 = 1'b0;
      m8_drv = (k >= 17);
      m8_val = 8'h45;
      #1;
      if (k >= 1 && k <= 16) begin
        chk("drop E", 32'(e8), 32'(((k - 1) >= TAS) && ((k - 1) < TAS + TEH)));
        chk("drop bus", 32'(d8), 32'(8'h55));
      end
      if (k >= 17) begin
        chk("drop idle E", 32'(e8), 32'(0));
        chk("drop idle bus", 32'(d8), 32'(8'h45));
      end
    end
    repeat (PH + 2) @(posedge clk);
    #1 m8_drv = 1'b0;

`ifdef LCD_BUSY_POLL_EN
    // Write followed by automatic status reads: BF=1, BF=1, then 0x00.
    f0 = falls8;
    e.lat = 4 * PH; e.rdata = last_rd8;
    sb.push_back(e);
    done = 1'b0;
    @(posedge clk); #1;
    address = 2'd0; writedata = 8'h01; write8 = 1'b1;
    for (int k = 0; k < 8 * PH && !done; k++) begin
      @(negedge clk);
      m8_drv = rw8 && (k > PH);
      m8_val = ((falls8 - f0) <= 2) ? 8'h80 : 8'h00;
      #1;
      if (!wait8) begin
        done = 1'b1;
        e = sb.pop_front();
        chk("poll latency", 32'(k), 32'(e.lat));
        chk("poll readdata", 32'(rd8), 32'(e.rdata));
      end
    end
    chk("poll completed", 32'(done), 32'(1));
    chk("poll E pulses", 32'(falls8 - f0), 32'(4));
    @(posedge clk); #1;
    write8 = 1'b0; m8_drv = 1'b0;
`else
    f0 = 0;
    done = 1'b0;
`endif

    txn(1'b1, 2'd2, 1'b0, 1'b1, 8'hA7, 8'h00, "w4 A7");
    txn(1'b1, 2'd3, 1'b1, 1'b0, 8'hFF, 8'hC3, "r4 C3");

    // Reset in the middle of an E-high phase of a write.
    @(posedge clk); #1;
    address = 2'd2; writedata = 8'h38; write8 = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("pre-reset E", 32'(e8), 32'(1));
    reset_n = 1'b0;
    m8_drv  = 1'b1;
    m8_val  = 8'hC5;
    #1;
    chk("mid-rst E", 32'(e8), 32'(0));
    chk("mid-rst RW", 32'(rw8), 32'(1));
    chk("mid-rst RS", 32'(rs8), 32'(0));
    chk("mid-rst bus", 32'(d8), 32'(8'hC5));
    chk("mid-rst readdata", 32'(rd8), 32'(0));
    chk("mid-rst readdata4", 32'(rd4), 32'(0));
    chk("mid-rst waitrequest", 32'(wait8), 32'(1));
    write8 = 1'b0;
    #1;
    chk("mid-rst waitrequest low", 32'(wait8), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    m8_drv  = 1'b0;
    last_rd8 = 8'h00;
    last_rd4 = 8'h00;
    txn(1'b0, 2'd0, 1'b0, 1'b1, 8'h0C, 8'h00, "post-rst w8 0C");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
